// File: rtl/efc_pkg.sv
// Shared definitions for the efuse serial-to-parallel latch loader:
// FSM state encoding and the counter width helper.
package efc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    SETUP = 3'd2,
    OPEN  = 3'd3,
    HOLD  = 3'd4
  } efc_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int efc_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/efc_sreg.sv
// Serial word assembler: shifts in MSB-first bits and counts them.
// word presents the value shreg will hold after this cycle's transfer.
module efc_sreg
  import efc_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            shift_en,
  input  logic            sdata,
  output logic [SIZE-1:0] word,
  output logic            full
);

  localparam int CW = efc_cw(SIZE + 1);

  logic [SIZE-1:0] shreg;
  logic [CW-1:0]   bitcnt;

  assign word = shift_en ? {shreg[SIZE-2:0], sdata} : shreg;
  // High on the transfer that completes the word, so the FSM can leave SHIFT on that edge.
  assign full = shift_en && (bitcnt == CW'(SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (clr) begin
      bitcnt <= '0;
    end else if (shift_en) begin
      shreg  <= word;
      bitcnt <= bitcnt + 1'b1;
    end
  end

endmodule

// File: rtl/efc_shift_deser.sv
// Loads NBANK efuse latch banks from a serial bit stream, one SIZE-bit word per bank,
// framing each active-low latch open with a setup and a hold cycle of stable lat_d.
module efc_shift_deser
  import efc_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int NBANK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sdata,
  input  logic             sdata_vld,
  output logic             sdata_rdy,
  output logic [SIZE-1:0]  lat_d,
  output logic [NBANK-1:0] lat_c,
  output logic             busy,
  output logic             done
);

  localparam int BW = efc_cw(NBANK);

  efc_state_e      state;
  logic [BW-1:0]   bank;
  logic            last_bank;
  logic            shift_en;
  logic            clr;
  logic            full;
  logic [SIZE-1:0] word;

  // Handshake: a bit moves only on a cycle where sdata_vld && sdata_rdy are both high;
  // sdata_rdy depends on registered state only, and a bit offered alongside abort is dropped.
  assign sdata_rdy = (state == SHIFT);
  assign busy      = (state != IDLE);
  assign last_bank = (bank == BW'(NBANK - 1));
  assign shift_en  = sdata_rdy && sdata_vld && !abort;
  assign clr       = !abort && (((state == IDLE) && start) || ((state == HOLD) && !last_bank));

  efc_sreg #(.SIZE(SIZE)) u_sreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .sdata    (sdata),
    .word     (word),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bank  <= '0;
      lat_d <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= SHIFT;
              bank  <= '0;
            end
          end
          SHIFT: begin
            if (full) begin
              state <= SETUP;
              lat_d <= word;
            end
          end
          SETUP: state <= OPEN;
          OPEN:  state <= HOLD;
          HOLD: begin
            if (last_bank) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              bank  <= bank + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    lat_c = '1;
    for (int k = 0; k < NBANK; k++) begin
      lat_c[k] = !((state == OPEN) && (bank == BW'(k)));
    end
  end

endmodule

// File: tb/tb_efc_shift_deser.sv
// Bench for efc_shift_deser: a 32x4 instance driven through full, stalled, aborted,
// restarted and reset runs, plus a 2x1 corner instance.
module tb_efc_shift_deser;

  logic        clk = 1'b0;
  logic        rst, start, abort, sdata, sdata_vld;
  logic        sdata_rdy, busy, done;
  logic [31:0] lat_d;
  logic [3:0]  lat_c;

  logic        s_rst, s_start, s_abort, s_sdata, s_sdata_vld;
  logic        s_sdata_rdy, s_busy, s_done;
  logic [1:0]  s_lat_d;
  logic [0:0]  s_lat_c;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] words [4];

  always #5 clk = ~clk;

  efc_shift_deser #(.SIZE(32), .NBANK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sdata(sdata),
    .sdata_vld(sdata_vld), .sdata_rdy(sdata_rdy), .lat_d(lat_d), .lat_c(lat_c),
    .busy(busy), .done(done)
  );

  efc_shift_deser #(.SIZE(2), .NBANK(1)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort), .sdata(s_sdata),
    .sdata_vld(s_sdata_vld), .sdata_rdy(s_sdata_rdy), .lat_d(s_lat_d), .lat_c(s_lat_c),
    .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_lat_c"}, lat_c, 4'hF);
    chk({tag, "_rdy"}, sdata_rdy, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // One load run. Called at a negedge. mode: 0 continuous vld, 1 vld low every other
  // offered cycle, 2 random vld. abort_bank/rst_bank < 0 disables that interruption.
  task automatic run32(input int mode, input int abort_bank, input int rst_bank,
                       input int restart_cyc);
    int          ptr = 0;
    int          opened = 0;
    int          cyc = 0;
    int          stalls = 0;
    int          ndone = 0;
    int          exp_done;
    bit          tog = 1'b0;
    bit          pend_hold = 1'b0;
    bit          got_done = 1'b0;
    logic        v;
    logic [3:0]  exp_c;
    logic [31:0] prev_d;
    logic [31:0] cur;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("rdy_after_start", sdata_rdy, 1'b1);
    prev_d = lat_d;
    while (!got_done && cyc < 2000) begin
      if (pend_hold) begin
        chk("hold_lat_d", lat_d, words[opened-1]);
        chk("lat_c_one_cycle", lat_c, 4'hF);
        pend_hold = 1'b0;
      end
      if (lat_c !== 4'hF) begin
        if (opened >= 4) begin
          chk("extra_open", opened, 3);
        end else begin
          exp_c = ~(4'b0001 << opened);
          chk("lat_c_bank", lat_c, exp_c);
          chk("lat_d_word", lat_d, words[opened]);
          chk("setup_lat_d", prev_d, lat_d);
          opened++;
          pend_hold = 1'b1;
          if (opened - 1 == abort_bank) begin
            abort = 1'b1;
            sdata_vld = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            chk_idle("after_abort");
            repeat (40) begin
              @(negedge clk);
              if (done) ndone++;
            end
            chk("no_done_after_abort", ndone, 0);
            return;
          end
          if (opened - 1 == rst_bank) begin
            sdata_vld = 1'b0;
            @(negedge clk);
            chk("hold_before_rst", lat_d, words[opened-1]);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_idle("after_rst");
            chk("after_rst_lat_d", lat_d, 32'h0);
            return;
          end
        end
      end
      if (done) begin
        exp_done = 4 * 35 + ((mode == 1) ? 128 : stalls);
        chk("done_cycle", cyc, exp_done);
        chk("banks_opened", opened, 4);
        chk("busy_at_done", busy, 1'b0);
        got_done = 1'b1;
      end
      // Drive inputs for the next edge.
      start = (cyc == restart_cyc);
      sdata = 1'($urandom_range(0, 1));
      if (sdata_rdy) begin
        case (mode)
          0:       v = 1'b1;
          1:       begin v = tog; tog = ~tog; end
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (v && ptr < 128) begin
          cur   = words[ptr / 32];
          sdata = cur[31 - (ptr % 32)];
          ptr++;
        end else begin
          stalls++;
        end
        sdata_vld = v;
      end else begin
        sdata_vld = 1'($urandom_range(0, 1));
      end
      prev_d = lat_d;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    sdata_vld = 1'b0;
    if (!got_done) chk("done_timeout", 1'b0, 1'b1);
    chk("done_pulse_width", done, 1'b0);
    chk("idle_after_run", busy, 1'b0);
  endtask

  task automatic run_small();
    logic [1:0] stream;
    int         ptr = 0;
    int         cyc = 0;
    int         opens = 0;
    bit         got = 1'b0;
    stream = 2'b10;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_busy_after_start", s_busy, 1'b1);
    while (!got && cyc < 50) begin
      if (s_lat_c !== 1'b1) begin
        opens++;
        chk("s_lat_c_open", s_lat_c, 1'b0);
        chk("s_lat_d", s_lat_d, 2'b10);
      end
      if (s_done) begin
        chk("s_done_cycle", cyc, 5);
        got = 1'b1;
      end
      s_sdata_vld = s_sdata_rdy && (ptr < 2);
      s_sdata = (ptr < 2) ? stream[1 - ptr] : 1'b0;
      if (s_sdata_vld) ptr++;
      @(negedge clk);
      cyc++;
    end
    s_sdata_vld = 1'b0;
    if (!got) chk("s_done_timeout", 1'b0, 1'b1);
    chk("s_opens", opens, 1);
    chk("s_lat_d_final", s_lat_d, 2'b10);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; sdata = 1'b0; sdata_vld = 1'b0;
    s_rst = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_sdata = 1'b0; s_sdata_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s_rst = 1'b0;
    chk_idle("reset");
    chk("reset_lat_d", lat_d, 32'h0);
    chk("s_reset_lat_c", s_lat_c, 1'b1);
    chk("s_reset_lat_d", s_lat_d, 2'b00);
    @(negedge clk);

    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
    words[2] = 32'h00000000; words[3] = 32'hFFFFFFFF;
    run32(0, -1, -1, -1);
    run32(1, -1, -1, -1);
    run32(0, 1, -1, -1);
    run32(0, -1, -1, -1);
    run32(0, -1, -1, 10);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      run32(2, -1, -1, -1);
    end

    words[0] = 32'hA5A5A5A5; words[1] = 32'h0F0F0F0F;
    words[2] = 32'h80000001; words[3] = 32'h7FFFFFFE;
    run32(0, -1, 2, -1);
    run32(2, -1, -1, -1);

    run_small();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
